clk_div_multi: RTL
==================

Name: clk_div_multi

Overview:
- Multi-channel programmable clock divider fed by PLL_CLK.
- Produces N_CH divided clocks for the DDS datapath, DAC and auxiliary logic. Each channel has its own runtime divide ratio, enable and optional half-PLL-cycle (negedge) phase offset.
- Ratio changes and enable/disable are glitch-free.
- A common sync pulse re-aligns all channels.

Parameters:
- DIV_W, 8: width of each per-channel half-period count.
- N_CH, 2: number of output channels.
- DIV_RST, 0: D_act and D_sh value after reset (0 gives divide-by-2).
- PHASE_MASK, 2'b10 (N_CH bits): bit i = 1 makes channel i output on the negedge-retimed copy (half PLL cycle later).

Ports:
- PLL_CLK  in  1  source clock; all state is on posedge except the negedge retime flops.
- RESETn  in  1  asynchronous, active-low reset.
- div_i  in  N_CH*DIV_W  per-channel half-period count D; channel i uses bits [i*DIV_W +: DIV_W].
- load_i  in  N_CH  per-channel 1-cycle strobe that captures div_i slice into the shadow register.
- en_i  in  N_CH  per-channel run enable (level).
- sync_i  in  1  1-cycle strobe that restarts all channels aligned.
- clk_o  out  N_CH  divided clocks.
- busy_o  out  N_CH  shadow update pending for that channel.

Behaviour:
- Reset (async): cnt=0, q=0, q_n=0, D_act=D_sh=DIV_RST, pending=0, run=0.
  - All outputs are 0 during and after reset: clk_o=0, busy_o=0.
- Per channel: cnt counts 0..D_act. At cnt==D_act, cnt<=0 and q toggles.
  - Output period = 2*(D_act+1) PLL cycles, 50% duty.
  - D=0 gives /2; D=255 gives /512.
- q_n: q re-registered on negedge PLL_CLK.
- clk_o[i]: equals q when PHASE_MASK[i]=0, q_n when PHASE_MASK[i]=1. The phase is static, so there is no runtime mux switching.
- Load:
  - load_i[i] sets D_sh<=div slice and pending<=1, so busy_o rises the next cycle.
  - A load while pending overwrites D_sh; pending stays 1.
- Apply point is the falling wrap (cnt==D_act && q==1):
  - D_act<=D_sh and pending<=0 on that edge.
  - The following low half-period already uses the new D. No runt pulse is possible.
  - A load on the same edge as a falling wrap is not applied at that wrap; it waits for the next one.
- Enable:
  - run follows en_i with one register stage.
  - en low while run=1: the channel keeps counting until the next falling wrap, then freezes with cnt=0, q=0.
  - en high while stopped: counting starts the next cycle from cnt=0, q=0. The first rising edge of q comes D_act+1 cycles after run=1.
  - While stopped, a pending update is applied immediately (next cycle).
- Sync (priority over load apply and enable edges):
  - For every channel with run or en set: cnt<=0, q<=0, and D_act<=D_sh if pending (pending cleared).
  - This may truncate a high phase. Truncation is intended; sync is only issued while the consumers are idle.
  - load_i coincident with sync_i: the new value is captured into D_sh and stays pending, not applied by that sync.
- No combinational path from inputs to clk_o. busy_o is registered.

Decomposition:
- Shared package dds_clk_pkg holds DIV_W default, the DIV_RST default and the per-channel slice helper.
- One sub-module, clk_div_chan: a single channel with cnt/q/q_n/D_act/D_sh/pending/run. It is instantiated N_CH times in a generate loop, and PHASE_MASK[i] is passed as that channel's parameter.
- Top level only slices the buses and fans out sync_i.

Test Plan:
1. Reset defaults (DIV_RST=0, en=2'b11): clk_o[0] toggles every PLL posedge (/2). clk_o[1] is identical but shifted half a PLL cycle. Both are 0 while RESETn=0.
2. Ratio change: ch0 with D=3, load D=1 mid high phase → the current high lasts 4 cycles, then low lasts 2 cycles. busy_o[0] goes 1→0 at the falling wrap. No pulse shorter than 2 cycles.
3. Load coincident with falling wrap (D=2 → 5): the next low uses 3 cycles. The new value applies at the following falling wrap. busy_o stays high across one full period.
4. Disable mid-high (D=4): clk_o stays high until its 5-cycle high completes, then holds 0. Re-enable: the first rising edge comes 5 cycles after run=1.
5. Sync with ch0 D=2 and ch1 D=6 free-running: after sync_i, both q=0. Rising edges come at +3 and +7 cycles. Ch1 output is delayed half a PLL cycle.
6. Async reset asserted mid-period with pending=1: all outputs 0 immediately. After release, D_act=DIV_RST and busy_o=0.

Source files
------------

// File: rtl/dds_clk_pkg.sv
// Shared defaults and bus-slicing helper for the DDS clock dividers.
package dds_clk_pkg;

  localparam int unsigned DIV_W_DEF   = 8;
  localparam int unsigned DIV_RST_DEF = 0;

  // LSB position of channel ch inside a packed per-channel bus of width w.
  function automatic int unsigned chan_lsb(input int unsigned ch, input int unsigned w);
    return ch * w;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: half-period counter with shadowed ratio, glitch-free enable,
// sync restart and an optional negedge-retimed output.
module clk_div_chan #(
  parameter int unsigned      DIV_W   = 8,
  parameter logic [DIV_W-1:0] DIV_RST = '0,
  parameter bit               PHASE   = 1'b0
) (
  input  logic             PLL_CLK,
  input  logic             RESETn,
  input  logic [DIV_W-1:0] div_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic             sync_i,
  output logic             clk_o,
  output logic             busy_o
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] d_act;
  logic [DIV_W-1:0] d_sh;
  logic             q;
  logic             q_n;
  logic             pending;
  logic             run;
  logic             wrap;
  logic             active;

  assign wrap   = (cnt == d_act);
  // A channel whose run dropped keeps going until it is back at the idle point.
  assign active = run || q || (cnt != '0);

  always_ff @(posedge PLL_CLK or negedge RESETn) begin
    if (!RESETn) begin
      cnt     <= '0;
      q       <= 1'b0;
      d_act   <= DIV_RST;
      d_sh    <= DIV_RST;
      pending <= 1'b0;
      run     <= 1'b0;
    end else begin
      run <= en_i;
      if (sync_i && (run || en_i)) begin
        cnt <= '0;
        q   <= 1'b0;
        if (pending) begin
          d_act   <= d_sh;
          pending <= 1'b0;
        end
      end else if (active) begin
        if (wrap) begin
          cnt <= '0;
          q   <= ~q;
          // Only the falling wrap may take a new ratio, so no runt pulse.
          if (q && pending) begin
            d_act   <= d_sh;
            pending <= 1'b0;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (pending) begin
        d_act   <= d_sh;
        pending <= 1'b0;
      end
      // Placed last so a coincident load always survives as pending.
      if (load_i) begin
        d_sh    <= div_i;
        pending <= 1'b1;
      end
    end
  end

  always_ff @(negedge PLL_CLK or negedge RESETn) begin
    if (!RESETn) q_n <= 1'b0;
    else         q_n <= q;
  end

  assign clk_o  = PHASE ? q_n : q;
  assign busy_o = pending;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: slices the buses and fans out sync.
module clk_div_multi
  import dds_clk_pkg::*;
#(
  parameter int unsigned         DIV_W      = DIV_W_DEF,
  parameter int unsigned         N_CH       = 2,
  parameter int unsigned         DIV_RST    = DIV_RST_DEF,
  parameter logic [N_CH-1:0]     PHASE_MASK = N_CH'(2'b10)
) (
  input  logic                   PLL_CLK,
  input  logic                   RESETn,
  input  logic [N_CH*DIV_W-1:0]  div_i,
  input  logic [N_CH-1:0]        load_i,
  input  logic [N_CH-1:0]        en_i,
  input  logic                   sync_i,
  output logic [N_CH-1:0]        clk_o,
  output logic [N_CH-1:0]        busy_o
);

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    clk_div_chan #(
      .DIV_W   (DIV_W),
      .DIV_RST (DIV_W'(DIV_RST)),
      .PHASE   (PHASE_MASK[i])
    ) u_chan (
      .PLL_CLK (PLL_CLK),
      .RESETn  (RESETn),
      .div_i   (div_i[chan_lsb(i, DIV_W) +: DIV_W]),
      .load_i  (load_i[i]),
      .en_i    (en_i[i]),
      .sync_i  (sync_i),
      .clk_o   (clk_o[i]),
      .busy_o  (busy_o[i])
    );
  end

endmodule
